// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier family.
package mult_pkg;

  // Defaults shared with the other multipliers in the datapath.
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_APPROX_BITS = 0;

  // Control states of the shift-add sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an iteration counter that must reach WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/loa_adder.sv
// Lower-part-OR approximate adder: the low APPROX_BITS are plain ORs with no
// carry into the upper part; the upper bits are an exact carry-propagate sum
// whose carry out becomes sum[WIDTH].
module loa_adder #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  generate
    if (APPROX_BITS > 0) begin : g_lower
      assign sum[APPROX_BITS-1:0] = a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0];
    end

    if (APPROX_BITS < WIDTH) begin : g_upper
      // Carry-in of the exact part is zero: the OR region never generates one.
      assign sum[WIDTH:APPROX_BITS] = {1'b0, a[WIDTH-1:APPROX_BITS]}
                                    + {1'b0, b[WIDTH-1:APPROX_BITS]};
    end else begin : g_all_or
      assign sum[WIDTH] = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seq_approx_mult.sv
// Radix-2 shift-add multiplier: one conditional approximate add per cycle,
// WIDTH cycles per product, valid/ready on both sides.
module seq_approx_mult
  import mult_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mq;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     loa_sum;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               last_iter;

  loa_adder #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_loa (
    .a   (acc_hi),
    .b   (mcand),
    .sum (loa_sum)
  );

  // Add the multiplicand only when the current multiplier bit is set.
  assign sum       = mq[0] ? loa_sum : {1'b0, acc_hi};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign accept    = in_valid & in_ready;
  assign out_p     = {acc_hi, mq};

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Releasing the product and taking a new pair share one edge.
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it is part of the
    // synchronous logic rather than an asynchronous clear.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand load, per-iteration shift of {acc_hi, mq}, and iteration count.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, which the shift relies on.
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      mq     <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= in_a;
      mq     <= in_b;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc_hi <= sum[WIDTH:1];
      mq     <= {sum[0], mq[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_approx_mult.sv
// Bench for seq_approx_mult: four instances (APPROX_BITS 0, 2, 3, 8) run in
// lockstep on shared stimulus; each product is compared with a behavioural
// model of the lower-part-OR shift-add algorithm, and the exact one with a*b.
module tb_seq_approx_mult;

  localparam int W  = 8;
  localparam int ND = 4;
  localparam int N_RANDOM = 1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready  [ND];
  logic           out_valid [ND];
  logic           busy      [ND];
  logic [2*W-1:0] out_p     [ND];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a;
    int b;
  } pair_t;

  always #5 clk = ~clk;

  function automatic int ab_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int AB = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
      seq_approx_mult #(
        .WIDTH       (W),
        .APPROX_BITS (AB)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready[g]),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid[g]),
        .out_ready (out_ready),
        .out_p     (out_p[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  // Approximate add: low ab bits ORed, upper bits summed exactly, carry kept.
  function automatic int loa_model(input int x, input int y, input int ab);
    int lo;
    int hi;
    lo = (x | y) & ((1 << ab) - 1);
    hi = (x >> ab) + (y >> ab);
    return (hi << ab) | lo;
  endfunction

  // Radix-2 shift-add with the approximate adder, as integer arithmetic.
  function automatic logic [2*W-1:0] ref_product(input int a, input int b, input int ab);
    int hi;
    int q;
    int s;
    int full;
    hi = 0;
    q  = b;
    for (int i = 0; i < W; i++) begin
      s    = (q % 2 == 1) ? loa_model(hi, a, ab) : hi;
      full = s * (1 << (W - 1)) + q / 2;
      hi   = full / (1 << W);
      q    = full % (1 << W);
    end
    return (2*W)'(hi * (1 << W) + q);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int a, input int b);
    in_a     = W'(a);
    in_b     = W'(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, giving up after 20.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid[0] && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({in_ready[d], out_valid[d], busy[d]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got in_ready/out_valid/busy=%b%b%b, expected 100",
                 d, in_ready[d], out_valid[d], busy[d]);
      end
      n_tests++;
      if (out_p[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_out_p dut%0d: got %0d, expected 0", d, out_p[d]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_exact_latency();
    start_op(13, 11);
    for (int k = 0; k < W; k++) begin
      n_tests++;
      if ({busy[0], out_valid[0], in_ready[0]} !== 3'b100) begin
        n_fail++;
        $display("FAIL run_flags k=%0d: got busy/out_valid/in_ready=%b%b%b, expected 100",
                 k, busy[0], out_valid[0], in_ready[0]);
      end
      step();
    end
    n_tests++;
    if ({out_valid[0], busy[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_13x11: got out_valid/busy=%b%b after %0d edges, expected 10",
               out_valid[0], busy[0], W);
    end
    n_tests++;
    if (out_p[0] !== 16'd143) begin
      n_fail++;
      $display("FAIL exact_13x11: got %0d, expected 143", out_p[0]);
    end
    for (int d = 1; d < ND; d++) begin
      n_tests++;
      if (out_p[d] !== ref_product(13, 11, ab_of(d))) begin
        n_fail++;
        $display("FAIL approx_13x11 dut%0d: got %0d, expected %0d",
                 d, out_p[d], ref_product(13, 11, ab_of(d)));
      end
    end
    drain();
  endtask

  task automatic test_corners();
    int ca [3] = '{255, 0, 1};
    int cb [3] = '{255, 200, 1};
    int cycles;
    logic saw_ready;
    for (int t = 0; t < 3; t++) begin
      start_op(ca[t], cb[t]);
      cycles    = 0;
      saw_ready = 1'b0;
      while (!out_valid[0] && cycles < 20) begin
        saw_ready = saw_ready | in_ready[0];
        step();
        cycles++;
      end
      n_tests++;
      if (cycles != W) begin
        n_fail++;
        $display("FAIL corner_latency %0dx%0d: got %0d edges, expected %0d",
                 ca[t], cb[t], cycles, W);
      end
      n_tests++;
      if (saw_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL corner_in_ready %0dx%0d: got in_ready=1 during RUN, expected 0",
                 ca[t], cb[t]);
      end
      n_tests++;
      if (out_p[0] !== (2*W)'(ca[t] * cb[t])) begin
        n_fail++;
        $display("FAIL corner_exact %0dx%0d: got %0d, expected %0d",
                 ca[t], cb[t], out_p[0], ca[t] * cb[t]);
      end
      drain();
    end
  endtask

  task automatic test_approx();
    int cycles;
    start_op(3, 3);
    wait_valid(cycles);
    n_tests++;
    if (out_p[0] !== 16'd9) begin
      n_fail++;
      $display("FAIL approx0_3x3: got %0d, expected 9", out_p[0]);
    end
    n_tests++;
    if (out_p[1] !== 16'd7) begin
      n_fail++;
      $display("FAIL approx2_3x3: got %0d, expected 7", out_p[1]);
    end
    n_tests++;
    if (out_p[2] !== ref_product(3, 3, 3)) begin
      n_fail++;
      $display("FAIL approx3_3x3: got %0d, expected %0d", out_p[2], ref_product(3, 3, 3));
    end
    n_tests++;
    if (out_p[3] !== ref_product(3, 3, 8)) begin
      n_fail++;
      $display("FAIL approx8_3x3: got %0d, expected %0d", out_p[3], ref_product(3, 3, 8));
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int cycles;
    start_op(13, 11);
    wait_valid(cycles);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({out_valid[0], in_ready[0]} !== 2'b10) begin
        n_fail++;
        $display("FAIL stall_flags k=%0d: got out_valid/in_ready=%b%b, expected 10",
                 k, out_valid[0], in_ready[0]);
      end
      for (int d = 0; d < ND; d++) begin
        n_tests++;
        if (out_p[d] !== ref_product(13, 11, ab_of(d))) begin
          n_fail++;
          $display("FAIL stall_hold dut%0d k=%0d: got %0d, expected %0d",
                   d, k, out_p[d], ref_product(13, 11, ab_of(d)));
        end
      end
      step();
    end
    in_a      = 8'd7;
    in_b      = 8'd6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got in_ready=%b, expected 1", in_ready[0]);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid[0], busy[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_load: got out_valid/busy=%b%b, expected 01", out_valid[0], busy[0]);
    end
    wait_valid(cycles);
    n_tests++;
    if (cycles != W) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d edges, expected %0d", cycles, W);
    end
    n_tests++;
    if (out_p[0] !== 16'd42) begin
      n_fail++;
      $display("FAIL b2b_7x6: got %0d, expected 42", out_p[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int cycles;
    start_op(200, 150);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({out_valid[d], in_ready[d], busy[d]} !== 3'b010) begin
        n_fail++;
        $display("FAIL midreset_flags dut%0d: got out_valid/in_ready/busy=%b%b%b, expected 010",
                 d, out_valid[d], in_ready[d], busy[d]);
      end
    end
    rst = 1'b0;
    step();
    start_op(13, 11);
    wait_valid(cycles);
    n_tests++;
    if (cycles != W || out_p[0] !== 16'd143) begin
      n_fail++;
      $display("FAIL midreset_after: got %0d after %0d edges, expected 143 after %0d",
               out_p[0], cycles, W);
    end
    drain();
  endtask

  task automatic test_random();
    pair_t q[$];
    pair_t pr;
    pair_t nx;
    int sent   = 0;
    int got    = 0;
    int cycles = 0;
    logic accepted;
    while ((sent < N_RANDOM || q.size() > 0) && cycles < 60000) begin
      if (!in_valid && sent < N_RANDOM) begin
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        if ($urandom_range(0, 15) == 0) in_a = '0;
        if ($urandom_range(0, 15) == 0) in_b = '1;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      accepted = 1'b0;
      if (out_valid[0] && out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_extra: got product %0d with nothing outstanding", out_p[0]);
        end else begin
          pr = q.pop_front();
          got++;
          n_tests++;
          if (out_p[0] !== (2*W)'(pr.a * pr.b)) begin
            n_fail++;
            $display("FAIL rand_exact %0dx%0d: got %0d, expected %0d",
                     pr.a, pr.b, out_p[0], pr.a * pr.b);
          end
          for (int d = 1; d < ND; d++) begin
            n_tests++;
            if (out_p[d] !== ref_product(pr.a, pr.b, ab_of(d))) begin
              n_fail++;
              $display("FAIL rand_approx dut%0d %0dx%0d: got %0d, expected %0d",
                       d, pr.a, pr.b, out_p[d], ref_product(pr.a, pr.b, ab_of(d)));
            end
          end
        end
      end
      if (in_valid && in_ready[0]) begin
        nx.a = int'(in_a);
        nx.b = int'(in_b);
        q.push_back(nx);
        sent++;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (accepted) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got != N_RANDOM || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d products with %0d outstanding after %0d cycles, expected %0d and 0",
               got, q.size(), cycles, N_RANDOM);
    end
  endtask

  initial begin
    test_reset();
    test_exact_latency();
    test_corners();
    test_approx();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
